// File: rtl/alu_serial_if.sv
// rtl/alu_serial_if.sv - operand/result handshake bundle for alu_serial
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, result, cout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, result, cout, zero, ovf
    );
endinterface

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - bit-serial NOR/XOR/ADD/SUB ALU, LSB first, one bit per cycle
// ALU_SERIAL_FLAGS_EN builds the zero/ovf flag logic; otherwise both flags read 0.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_serial_if.slave  bus
);
    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ai, bi, slice_bit, slice_carry, last_bit;

    // Operands shift right each RUN cycle, so the current slice is always bit 0.
    always_comb begin
        ai          = a_q[0];
        bi          = b_q[0];
        slice_bit   = 1'b0;
        slice_carry = 1'b0;
        case (op_q)
            OP_NOR: slice_bit = ~(ai | bi);
            OP_XOR: slice_bit = ai ^ bi;
            OP_ADD: begin
                slice_bit   = ai ^ bi ^ carry_q;
                slice_carry = (ai & bi) | (carry_q & (ai ^ bi));
            end
            default: begin
                slice_bit   = ai ^ bi ^ carry_q;
                slice_carry = (~ai & bi) | (~(ai ^ bi) & carry_q);
            end
        endcase
    end

    assign last_bit = (state_q == S_RUN) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {slice_bit, res_q[WIDTH-1:1]};
                carry_d = slice_carry;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    cout_d  = slice_carry;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_NOR;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic any_q, any_d;
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;

    // The final RUN slice sees the operand sign bits, so overflow is decided there.
    always_comb begin
        any_d  = any_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (state_q == S_IDLE && bus.in_valid) begin
            any_d = 1'b0;
        end else if (state_q == S_RUN) begin
            any_d = any_q | slice_bit;
            if (last_bit) begin
                zero_d = ~(any_q | slice_bit);
                case (op_q)
                    OP_ADD:  ovf_d = (ai == bi) && (slice_bit != ai);
                    OP_SUB:  ovf_d = (ai != bi) && (slice_bit != ai);
                    default: ovf_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            any_q  <= any_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`else
    assign bus.zero = 1'b0;
    assign bus.ovf  = 1'b0;
`endif
endmodule
